// File: rtl/axi_burst_writer.sv
// AXI4 write master: splits a (base address, word count) command into INCR bursts of at most
// MAX_BURST_LEN beats that never cross a 4 KiB page. Data passes straight from the input stream
// to the W channel with no buffering. Only one burst is outstanding at a time.
module axi_burst_writer #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 256,
  parameter int unsigned STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned MAX_BURST_LEN = 16,
  parameter int unsigned COUNT_WIDTH   = 24
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ADDR_WIDTH-1:0]  cmd_addr,
  input  logic [COUNT_WIDTH-1:0] cmd_words,
  input  logic [DATA_WIDTH-1:0]  s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [ADDR_WIDTH-1:0]  axi_awaddr,
  output logic [7:0]             axi_awlen,
  output logic [2:0]             axi_awsize,
  output logic [1:0]             axi_awburst,
  output logic                   axi_awvalid,
  input  logic                   axi_awready,
  output logic [DATA_WIDTH-1:0]  axi_wdata,
  output logic [STRB_WIDTH-1:0]  axi_wstrb,
  output logic                   axi_wlast,
  output logic                   axi_wvalid,
  input  logic                   axi_wready,
  input  logic                   axi_bvalid,
  output logic                   axi_bready,
  input  logic [1:0]             axi_bresp,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int unsigned Offs = $clog2(STRB_WIDTH);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [8:0]             beats_q, beats_d;
  logic [8:0]             beat_cnt_q, beat_cnt_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic [ADDR_WIDTH-1:0]  aligned_addr;
  logic [ADDR_WIDTH-1:0]  addr_next;
  logic [COUNT_WIDTH-1:0] remaining_next;
  logic                   last_beat;

  // Beats for the next burst: limited by words left, the burst cap and the page end.
  // 13-bit arithmetic keeps a full 4096-byte distance representable.
  function automatic logic [8:0] calc_beats(input logic [11:0]            addr_lo,
                                            input logic [COUNT_WIDTH-1:0] rem);
    logic [12:0] to_bnd;
    logic [12:0] n;
    to_bnd = (13'd4096 - {1'b0, addr_lo}) >> Offs;
    n = to_bnd;
    if (n > 13'(MAX_BURST_LEN)) n = 13'(MAX_BURST_LEN);
    if (32'(rem) < 32'(n)) n = 13'(rem);
    return 9'(n);
  endfunction

  assign aligned_addr   = cmd_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
  assign addr_next      = addr_q + (ADDR_WIDTH'(beats_q) << Offs);
  assign remaining_next = remaining_q - COUNT_WIDTH'(beats_q);
  assign last_beat      = (beat_cnt_q == beats_q - 9'd1);

  // State and datapath registers; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
      beat_cnt_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      beats_q     <= beats_d;
      beat_cnt_q  <= beat_cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    beats_d     = beats_q;
    beat_cnt_d  = beat_cnt_q;
    done_d      = 1'b0;
    err_d       = err_q;
    cmd_ready   = 1'b0;
    s_ready     = 1'b0;
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    axi_wlast   = 1'b0;
    axi_bready  = 1'b0;
    case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d      = aligned_addr;
          remaining_d = cmd_words;
          err_d       = 1'b0;
          if (cmd_words == '0) begin
            done_d = 1'b1;
          end else begin
            beats_d = calc_beats(aligned_addr[11:0], cmd_words);
            state_d = StAddr;
          end
        end
      end
      StAddr: begin
        axi_awvalid = 1'b1;
        if (axi_awready) begin
          beat_cnt_d = '0;
          state_d    = StData;
        end
      end
      StData: begin
        axi_wvalid = s_valid;
        s_ready    = axi_wready;
        axi_wlast  = last_beat;
        if (s_valid && axi_wready) begin
          beat_cnt_d = beat_cnt_q + 9'd1;
          if (last_beat) state_d = StResp;
        end
      end
      StResp: begin
        axi_bready = 1'b1;
        if (axi_bvalid) begin
          err_d       = err_q | (axi_bresp != 2'b00);
          addr_d      = addr_next;
          remaining_d = remaining_next;
          if (remaining_next == '0) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            beats_d = calc_beats(addr_next[11:0], remaining_next);
            state_d = StAddr;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign axi_awaddr  = addr_q;
  assign axi_awlen   = 8'(beats_q - 9'd1);
  assign axi_awsize  = 3'(Offs);
  assign axi_awburst = 2'b01;
  assign axi_wdata   = s_data;
  assign axi_wstrb   = '1;
  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_axi_burst_writer.sv
// Randomized bench for axi_burst_writer: an AXI slave/RAM model with random ready timing, a
// stream source with random gaps, and a transaction-level model of the expected bursts.
module tb_axi_burst_writer;

  localparam int DW = 256;
  localparam int SW = 32;
  localparam int ML = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cmd_valid, cmd_ready;
  logic [31:0]   cmd_addr;
  logic [23:0]   cmd_words;
  logic [DW-1:0] s_data;
  logic          s_valid, s_ready;
  logic [31:0]   axi_awaddr;
  logic [7:0]    axi_awlen;
  logic [2:0]    axi_awsize;
  logic [1:0]    axi_awburst;
  logic          axi_awvalid, axi_awready;
  logic [DW-1:0] axi_wdata;
  logic [SW-1:0] axi_wstrb;
  logic          axi_wlast, axi_wvalid, axi_wready;
  logic          axi_bvalid, axi_bready;
  logic [1:0]    axi_bresp;
  logic          busy, done, err;

  always #5 clk = ~clk;

  axi_burst_writer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .MAX_BURST_LEN(ML), .COUNT_WIDTH(24)
  ) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_words(cmd_words), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready), .axi_bresp(axi_bresp), .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } aw_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected burst list: walk the command in page/cap/remaining sized steps.
  aw_t plan_q[$];
  task automatic plan(input logic [31:0] base, input int unsigned words);
    int unsigned a, rem, to_bnd, b;
    plan_q.delete();
    a   = base & ~32'h1F;
    rem = words;
    while (rem > 0) begin
      to_bnd = (4096 - (a % 4096)) / SW;
      b = rem;
      if (b > ML) b = ML;
      if (b > to_bnd) b = to_bnd;
      plan_q.push_back('{a, 8'(b - 1)});
      a   = a + b * SW;
      rem = rem - b;
    end
  endtask

  // Shared state between the stimulus process and the slave/monitor process
  logic [DW-1:0] stream_q[$];
  logic [DW-1:0] exp_data[$];
  aw_t           exp_aw[$];
  aw_t           bq[$];
  logic [DW-1:0] mem[int unsigned];
  int            wbeat, b_delay, cyc, done_due, done_count, done_cyc, aw_count, wlast_count;
  int            w_total, bursts_in_cmd, err_burst, awvalid_seen, busy_seen, acc_cyc;
  int            rdy_pct = 70;
  int            sv_pct = 80;
  bit            b_phase, in_cmd, err_model, acc_flag, prev_stall, err_at_done;
  logic [1:0]    b_resp_next;
  logic [31:0]   prev_addr;
  logic [7:0]    prev_len;

  // Slave/RAM model and per-cycle compare: drive at negedge, sample 1 ns later.
  initial begin : mon
    aw_t e;
    bit  aw_phase, w_phase;
    done_due = -10;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'b00;
        s_valid = 1'b0; s_data = '0;
        stream_q.delete(); exp_data.delete(); exp_aw.delete(); bq.delete();
        wbeat = 0; b_phase = 0; b_delay = 0; in_cmd = 0; err_model = 0; prev_stall = 0;
        done_due = -10;
        continue;
      end
      axi_awready = ($urandom_range(99) < rdy_pct);
      axi_wready  = ($urandom_range(99) < rdy_pct);
      s_valid     = (stream_q.size() > 0) && ($urandom_range(99) < sv_pct);
      s_data      = (stream_q.size() > 0) ? stream_q[0] : {8{$urandom}};
      if (b_phase && b_delay == 0) begin
        axi_bvalid = 1'b1;
        axi_bresp  = b_resp_next;
      end else begin
        if (b_phase) b_delay--;
        axi_bvalid = 1'b0;
        axi_bresp  = 2'($urandom);
      end
      #1;
      if (!rstn) continue;
      cyc++;
      w_phase  = (bq.size() > 0);
      aw_phase = in_cmd && (exp_aw.size() > 0) && !w_phase && !b_phase;
      chk(busy == in_cmd, "busy", busy, in_cmd);
      chk(cmd_ready == !in_cmd, "cmd_ready", cmd_ready, !in_cmd);
      chk(axi_awvalid == aw_phase, "awvalid", axi_awvalid, aw_phase);
      chk(axi_wvalid == (w_phase && s_valid), "wvalid", axi_wvalid, w_phase && s_valid);
      chk(s_ready == (w_phase && axi_wready), "s_ready", s_ready, w_phase && axi_wready);
      chk(axi_bready == b_phase, "bready", axi_bready, b_phase);
      chk(done == (cyc == done_due), "done", done, cyc == done_due);
      chk(err == err_model, "err", err, err_model);
      if (prev_stall)
        chk(axi_awaddr == prev_addr && axi_awlen == prev_len, "aw_stable",
            {axi_awaddr, axi_awlen}, {prev_addr, prev_len});
      prev_stall = axi_awvalid && !axi_awready;
      prev_addr  = axi_awaddr;
      prev_len   = axi_awlen;
      if (axi_awvalid) awvalid_seen++;
      if (busy) busy_seen++;
      if (done) begin
        done_count++;
        done_cyc    = cyc;
        err_at_done = err;
      end
      if (cmd_valid && cmd_ready) begin
        acc_flag  = 1'b1;
        acc_cyc   = cyc;
        err_model = 1'b0;
        if (cmd_words == 0) done_due = cyc + 1;
        else in_cmd = 1'b1;
      end
      if (axi_bvalid && axi_bready) begin
        b_phase = 1'b0;
        if (axi_bresp != 2'b00) err_model = 1'b1;
        bursts_in_cmd++;
        if (exp_aw.size() == 0) begin
          in_cmd   = 1'b0;
          done_due = cyc + 1;
        end
      end
      if (s_valid && s_ready) void'(stream_q.pop_front());
      if (axi_wvalid && axi_wready) begin
        if (bq.size() == 0 || exp_data.size() == 0) begin
          chk(1'b0, "w_unexpected", axi_wdata, '0);
        end else begin
          chk(axi_wdata == exp_data[0], "wdata", axi_wdata, exp_data[0]);
          void'(exp_data.pop_front());
          chk(axi_wstrb == '1, "wstrb", axi_wstrb, {SW{1'b1}});
          chk(axi_wlast == (wbeat == bq[0].len), "wlast", axi_wlast, wbeat == bq[0].len);
          mem[(bq[0].addr >> 5) + wbeat] = axi_wdata;
          w_total++;
          if (axi_wlast) wlast_count++;
          if (wbeat == int'(bq[0].len)) begin
            void'(bq.pop_front());
            wbeat       = 0;
            b_phase     = 1'b1;
            b_delay     = $urandom_range(3);
            b_resp_next = (bursts_in_cmd == err_burst) ? 2'b10 : 2'b00;
          end else begin
            wbeat++;
          end
        end
      end
      if (axi_awvalid && axi_awready) begin
        if (exp_aw.size() == 0) begin
          chk(1'b0, "aw_unexpected", axi_awaddr, '0);
        end else begin
          e = exp_aw.pop_front();
          chk(axi_awaddr == e.addr, "awaddr", axi_awaddr, e.addr);
          chk(axi_awlen == e.len, "awlen", axi_awlen, e.len);
        end
        chk(axi_awsize == 3'd5 && axi_awburst == 2'b01, "awsize_burst",
            {axi_awsize, axi_awburst}, {3'd5, 2'b01});
        chk((axi_awaddr % 4096) + (axi_awlen + 1) * SW <= 4096, "no_4k_cross",
            axi_awaddr, axi_awlen);
        bq.push_back('{axi_awaddr, axi_awlen});
        wbeat = 0;
        aw_count++;
      end
    end
  end

  logic [DW-1:0] cmd_data[$];

  // Load the model with a command, present it, and wait for its acceptance.
  task automatic issue(input logic [31:0] addr, input int words, input bit inc, input int eb);
    int n;
    logic [DW-1:0] d;
    plan(addr, words);
    cmd_data.delete();
    mem.delete();
    for (int i = 0; i < words; i++) begin
      d = inc ? DW'(i) : {8{$urandom}};
      cmd_data.push_back(d);
      stream_q.push_back(d);
      exp_data.push_back(d);
    end
    exp_aw = plan_q;
    done_count = 0; aw_count = 0; wlast_count = 0; w_total = 0; bursts_in_cmd = 0;
    awvalid_seen = 0; busy_seen = 0; acc_flag = 0; err_burst = eb;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_words = 24'(words);
    #2;
    n = 0;
    while (!acc_flag && n < 20) begin
      @(negedge clk); #2; n++;
    end
    chk(acc_flag, "cmd_accept", acc_flag, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #2;
    chk(err == 1'b0, "err_cleared_on_accept", err, 1'b0);
  endtask

  task automatic run_cmd(input logic [31:0] addr, input int words, input bit inc, input int eb,
                         input bit exp_err);
    int n;
    int unsigned k;
    issue(addr, words, inc, eb);
    n = 0;
    while (done_count == 0 && n < 20000) begin
      @(negedge clk); #2; n++;
    end
    chk(done_count > 0, "done_timeout", done_count, 1);
    chk(err_at_done == exp_err, "err_at_done", err_at_done, exp_err);
    repeat (4) @(negedge clk);
    #2;
    chk(done_count == 1, "done_once", done_count, 1);
    chk(exp_aw.size() == 0 && exp_data.size() == 0, "all_traffic_seen",
        exp_aw.size(), exp_data.size());
    for (int i = 0; i < words; i++) begin
      k = ((addr & ~32'h1F) >> 5) + i;
      chk(mem.exists(k) && mem[k] == cmd_data[i], "ram_readback",
          mem.exists(k) ? mem[k] : '0, cmd_data[i]);
    end
  endtask

  initial begin
    cmd_valid = 0; cmd_addr = 0; cmd_words = 0; s_data = 0; s_valid = 0;
    axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = 0;
    cyc = 0;

    // Pin the burst model against hand-worked sequences
    plan(32'h1000, 40);
    chk(plan_q.size() == 3, "plan_a_count", plan_q.size(), 3);
    if (plan_q.size() == 3) begin
      chk(plan_q[0].addr == 32'h1000 && plan_q[0].len == 8'd15, "plan_a0",
          {plan_q[0].addr, plan_q[0].len}, {32'h1000, 8'd15});
      chk(plan_q[1].addr == 32'h1200 && plan_q[1].len == 8'd15, "plan_a1",
          {plan_q[1].addr, plan_q[1].len}, {32'h1200, 8'd15});
      chk(plan_q[2].addr == 32'h1400 && plan_q[2].len == 8'd7, "plan_a2",
          {plan_q[2].addr, plan_q[2].len}, {32'h1400, 8'd7});
    end
    plan(32'h1F80, 10);
    chk(plan_q.size() == 2, "plan_b_count", plan_q.size(), 2);
    if (plan_q.size() == 2) begin
      chk(plan_q[0].addr == 32'h1F80 && plan_q[0].len == 8'd3, "plan_b0",
          {plan_q[0].addr, plan_q[0].len}, {32'h1F80, 8'd3});
      chk(plan_q[1].addr == 32'h2000 && plan_q[1].len == 8'd5, "plan_b1",
          {plan_q[1].addr, plan_q[1].len}, {32'h2000, 8'd5});
    end

    // Reset values
    repeat (3) @(negedge clk);
    #2;
    chk(cmd_ready == 1'b1, "rst_cmd_ready", cmd_ready, 1'b1);
    chk({axi_awvalid, axi_wvalid, axi_bready, s_ready, busy, done, err} == 7'b0, "rst_outputs",
        {axi_awvalid, axi_wvalid, axi_bready, s_ready, busy, done, err}, 7'b0);
    @(posedge clk); #2;
    rstn = 1'b1;

    // Multi-burst, incrementing data
    run_cmd(32'h1000, 40, 1'b1, -1, 1'b0);
    chk(aw_count == 3, "t1_aw_count", aw_count, 3);

    // 4 KiB page crossing
    run_cmd(32'h1F80, 10, 1'b0, -1, 1'b0);
    chk(aw_count == 2, "t2_aw_count", aw_count, 2);

    // Zero-length command
    run_cmd(32'h0500, 0, 1'b0, -1, 1'b0);
    chk(awvalid_seen == 0, "zero_no_aw", awvalid_seen, 0);
    chk(busy_seen == 0, "zero_no_busy", busy_seen, 0);
    chk(done_cyc == acc_cyc + 1, "zero_done_latency", done_cyc - acc_cyc, 1);

    // Heavy backpressure on every channel
    rdy_pct = 40;
    sv_pct  = 50;
    run_cmd(32'h0, 300, 1'b0, -1, 1'b0);
    chk(wlast_count == 19, "bp_wlast_count", wlast_count, 19);
    chk(w_total == 300, "bp_beats", w_total, 300);
    rdy_pct = 70;
    sv_pct  = 80;

    // Error response on the second of three bursts; sticky until next command
    run_cmd(32'h4000, 48, 1'b0, 1, 1'b1);
    chk(aw_count == 3, "err_aw_count", aw_count, 3);
    chk(err == 1'b1, "err_sticky", err, 1'b1);
    run_cmd(32'h8000, 8, 1'b0, -1, 1'b0);

    // Reset in the middle of a data phase
    begin
      int n;
      issue(32'h0, 16, 1'b1, -1);
      n = 0;
      while (w_total < 5 && n < 5000) begin
        @(negedge clk); #2; n++;
      end
      chk(w_total == 5, "mid_reset_reach_beat5", w_total, 5);
      @(posedge clk); #2;
      rstn = 1'b0;
      #1;
      chk({axi_awvalid, axi_wvalid, axi_bready, s_ready, busy} == 5'b0, "mid_reset_outputs",
          {axi_awvalid, axi_wvalid, axi_bready, s_ready, busy}, 5'b0);
      chk(cmd_ready == 1'b1, "mid_reset_cmd_ready", cmd_ready, 1'b1);
      repeat (2) @(negedge clk);
      @(posedge clk); #2;
      rstn = 1'b1;
      awvalid_seen = 0;
      repeat (6) @(negedge clk);
      #2;
      chk(awvalid_seen == 0, "no_aw_after_reset", awvalid_seen, 0);
      chk(cmd_ready == 1'b1, "cmd_ready_after_reset", cmd_ready, 1'b1);
    end
    run_cmd(32'h3000, 4, 1'b0, -1, 1'b0);
    chk(aw_count == 1, "post_reset_aw_count", aw_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
